// File: rtl/mem_access_unit.sv
// Initiator for a single-cycle, word-wide data memory: byte/halfword/word loads and stores,
// with read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
module mem_access_unit #(
   parameter bit ERR_ON_MISALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RESP,
      S_ERR
   } state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_R = 2'b11;

   state_t state_q, state_d;

   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [1:0]  off_q, off_d;
   logic [15:0] wdata_q, wdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        req_bad;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      logic r;
      r = 1'b0;
      if (size == SZ_H && off[0])
         r = 1'b1;
      else if (size == SZ_W && off != 2'b00)
         r = 1'b1;
      return r;
   endfunction

   function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
      logic [1:0] r;
      r = off;
      if (size == SZ_H)
         r = {off[1], 1'b0};
      else if (size == SZ_W)
         r = 2'b00;
      return r;
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (size)
         SZ_B:    r = sgn ? {{24{b[7]}}, b} : {24'h0, b};
         SZ_H:    r = sgn ? {{16{h[15]}}, h} : {16'h0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] wdata,
                                         input logic [1:0] size, input logic [1:0] off);
      logic [31:0] r;
      r = word;
      if (size == SZ_B)
         r[{off, 3'b000} +: 8] = wdata[7:0];
      else
         r[{off[1], 4'b0000} +: 16] = wdata;
      return r;
   endfunction

   assign req_bad = (req_size == SZ_R) ||
                    (ERR_ON_MISALIGN && misaligned(req_size, req_addr[1:0]));

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      sgn_d        = sgn_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      resp_rdata_d = 32'h0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d       = req_we;
               size_d     = req_size;
               sgn_d      = req_signed;
               off_d      = align_off(req_size, req_addr[1:0]);
               wdata_d    = req_wdata[15:0];
               mem_addr_d = {2'b00, req_addr[31:2]};
               if (req_bad) begin
                  state_d = S_ERR;
               end else if (!req_we || req_size != SZ_W) begin
                  state_d = S_RD;
               end else begin
                  state_d     = S_WR;
                  mem_wdata_d = req_wdata;
               end
            end
         end
         S_RD: begin
            if (!we_q) begin
               resp_rdata_d = extract(mem_rdata, size_q, off_q, sgn_q);
               state_d      = S_RESP;
            end else begin
               mem_wdata_d = merge(mem_rdata, wdata_q, size_q, off_q);
               state_d     = S_WR;
            end
         end
         S_WR:    state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Request attributes are only meaningful after acceptance, so they carry no reset.
   always_ff @(posedge clk) begin
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
   assign resp_err   = (state_q == S_ERR);
   assign resp_rdata = resp_rdata_q;
   assign mem_we     = (state_q == S_WR);
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a 16-word behavioural memory.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:15];

   int total = 0;
   int bad   = 0;

   mem_access_unit #(.ERR_ON_MISALIGN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_we && mem_addr[31:4] == 28'h0)
         mem[mem_addr[3:0]] <= mem_wdata;
   assign mem_rdata = mem[mem_addr[3:0]];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request from IDLE, follow it to its response (bounded), return to IDLE.
   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int wecnt, output logic [31:0] weaddr, output logic [31:0] wedata);
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      lat = -1; rdata = 32'hx; err = 1'bx; wecnt = 0; weaddr = 32'hx; wedata = 32'hx;
      for (int c = 1; c <= 8; c++) begin
         if (mem_we) begin
            wecnt++;
            weaddr = mem_addr;
            wedata = mem_wdata;
         end
         if (resp_valid) begin
            lat = c; rdata = resp_rdata; err = resp_err;
            break;
         end
         step();
      end
      step();
   endtask

   int          lat, wecnt, acc, rsp;
   logic [31:0] rd, wa, wd;
   logic        er, acc_now;
   logic [31:0] hs_addr [0:2];
   logic [1:0]  hs_size [0:2];
   logic [31:0] hs_exp  [0:2];

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      step(); step();
      chk("rst_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err", {31'h0, resp_err}, 32'h0);
      chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      rst = 1'b1;
      step();

      // Word store then load
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, wecnt, wa, wd);
      chk("sw_lat", 32'(lat), 32'd2);
      chk("sw_wecnt", 32'(wecnt), 32'd1);
      chk("sw_addr", wa, 32'd4);
      chk("sw_wdata", wd, 32'hDEADBEEF);
      chk("sw_rdata", rd, 32'h0);
      chk("sw_err", {31'h0, er}, 32'h0);
      chk("sw_mem", mem[4], 32'hDEADBEEF);
      chk("sw_ready_after", {31'h0, req_ready}, 32'h1);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, wecnt, wa, wd);
      chk("lw_lat", 32'(lat), 32'd2);
      chk("lw_rdata", rd, 32'hDEADBEEF);
      chk("lw_wecnt", 32'(wecnt), 32'd0);
      chk("lw_mem_addr_held", mem_addr, 32'd4);

      // Byte/halfword loads, signed and unsigned
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, lat, rd, er, wecnt, wa, wd);
      chk("sw2_mem", mem[4], 32'h80FF7F01);
      do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rd, er, wecnt, wa, wd);
      chk("lb11", rd, 32'h0000007F);
      chk("lb11_lat", 32'(lat), 32'd2);
      do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, rd, er, wecnt, wa, wd);
      chk("lb12", rd, 32'hFFFFFFFF);
      do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, rd, er, wecnt, wa, wd);
      chk("lbu12", rd, 32'h000000FF);
      do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er, wecnt, wa, wd);
      chk("lh12", rd, 32'hFFFF80FF);
      do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er, wecnt, wa, wd);
      chk("lhu12", rd, 32'h000080FF);
      do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, rd, er, wecnt, wa, wd);
      chk("lh10", rd, 32'h00007F01);

      // Sub-word read-modify-write
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rd, er, wecnt, wa, wd);
      do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFFAA, lat, rd, er, wecnt, wa, wd);
      chk("sb_lat", 32'(lat), 32'd3);
      chk("sb_wecnt", 32'(wecnt), 32'd1);
      chk("sb_wdata", wd, 32'hAA223344);
      chk("sb_mem", mem[4], 32'hAA223344);
      chk("sb_rdata", rd, 32'h0);
      do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'h1234BEEF, lat, rd, er, wecnt, wa, wd);
      chk("sh_lat", 32'(lat), 32'd3);
      chk("sh_wdata", wd, 32'hAA22BEEF);
      chk("sh_mem", mem[4], 32'hAA22BEEF);

      // Misaligned and reserved size
      do_req(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, lat, rd, er, wecnt, wa, wd);
      chk("lh_mis_lat", 32'(lat), 32'd1);
      chk("lh_mis_err", {31'h0, er}, 32'h1);
      chk("lh_mis_rdata", rd, 32'h0);
      do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'h55555555, lat, rd, er, wecnt, wa, wd);
      chk("sw_mis_lat", 32'(lat), 32'd1);
      chk("sw_mis_err", {31'h0, er}, 32'h1);
      chk("sw_mis_wecnt", 32'(wecnt), 32'd0);
      do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h66666666, lat, rd, er, wecnt, wa, wd);
      chk("rsv_lat", 32'(lat), 32'd1);
      chk("rsv_err", {31'h0, er}, 32'h1);
      chk("rsv_wecnt", 32'(wecnt), 32'd0);
      chk("err_mem_unchanged", mem[4], 32'hAA22BEEF);

      // req_valid held high across three loads
      hs_addr[0] = 32'h10; hs_size[0] = 2'b10; hs_exp[0] = 32'hAA22BEEF;
      hs_addr[1] = 32'h13; hs_size[1] = 2'b00; hs_exp[1] = 32'h000000AA;
      hs_addr[2] = 32'h10; hs_size[2] = 2'b01; hs_exp[2] = 32'h0000BEEF;
      acc = 0; rsp = 0;
      req_we = 1'b0; req_signed = 1'b0;
      req_addr = hs_addr[0]; req_size = hs_size[0]; req_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
         acc_now = req_valid && req_ready;
         step();
         if (acc_now) begin
            acc++;
            chk("hs_ready_low", {31'h0, req_ready}, 32'h0);
            if (acc < 3) begin
               req_addr = hs_addr[acc]; req_size = hs_size[acc];
            end else begin
               req_valid = 1'b0;
            end
         end
         if (resp_valid) begin
            if (rsp < 3) chk("hs_rdata", resp_rdata, hs_exp[rsp]);
            rsp++;
         end
      end
      req_valid = 1'b0;
      chk("hs_accepts", 32'(acc), 32'd3);
      chk("hs_resps", 32'(rsp), 32'd3);

      // Reset during the read cycle of a sub-word store
      req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h00000055;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("ab_rd_we", {31'h0, mem_we}, 32'h0);
      rst = 1'b0;
      step();
      chk("ab_we", {31'h0, mem_we}, 32'h0);
      chk("ab_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("ab_ready", {31'h0, req_ready}, 32'h1);
      chk("ab_mem_addr", mem_addr, 32'h0);
      chk("ab_mem_wdata", mem_wdata, 32'h0);
      chk("ab_rdata", resp_rdata, 32'h0);
      chk("ab_err", {31'h0, resp_err}, 32'h0);
      rst = 1'b1;
      rsp = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (resp_valid || mem_we) rsp++;
      end
      chk("ab_no_activity", 32'(rsp), 32'd0);
      chk("ab_mem_unchanged", mem[4], 32'hAA22BEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the single-cycle data-memory interface.
- Accepts load/store requests (byte, halfword, word) from the datapath over a valid/ready handshake.
- Drives the word-wide memory's write-enable, word address and write data, and samples its combinational read port.
- Sub-word stores use read-modify-write. Sub-word loads are lane-extracted, with sign or zero extension.

Parameters:
- ERR_ON_MISALIGN, 1: 1 = misaligned request returns error and makes no memory access; 0 = low address bits forced to natural alignment and the access proceeds.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 at a rising edge resets).
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted when req_valid & req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, valid while resp_valid=1; 0 for stores.
- resp_err  out  1  misaligned or reserved size, valid while resp_valid=1.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word index = {2'b00, addr[31:2]}.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory combinational read data for mem_addr.

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset values: req_ready=1 (IDLE); resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- On acceptance the unit latches we, size, signed, addr and wdata. Inputs are ignored until it returns to IDLE.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]. A halfword uses lanes {addr[1]*2+1, addr[1]*2}.
- Misalignment rule:
  - halfword with addr[0]=1, or word with addr[1:0]!=0;
  - size=11 is always an error.
- States:
  - IDLE: req_ready=1. On acceptance go to ERR if in error, else RD for a load or sub-word store, else WR for a word store.
  - RD: mem_addr = latched word index, mem_we=0. At the end of the cycle, capture mem_rdata. Load -> RESP. Sub-word store -> WR, with mem_wdata = captured word with the selected lanes replaced by the low byte or half of wdata.
  - WR: mem_we=1 for exactly this one cycle; the memory writes at the closing edge. For a word store, mem_wdata = wdata. Next state RESP.
  - RESP: resp_valid=1, resp_err=0, resp_rdata = extracted and extended load data (0 for stores). Next state IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0, mem_we=0. Next state IDLE.
- Latency, counted from the accept edge T (resp_valid high in the listed cycle after T):
  - load: 2nd cycle;
  - word store: 2nd cycle;
  - sub-word store: 3rd cycle;
  - error: 1st cycle.
- mem_addr holds the latched index from the accept edge until the next acceptance; it does not return to 0.
- No response backpressure: resp_valid is a single-cycle pulse.
- req_ready falls the cycle after acceptance. A new request can be accepted in the cycle after RESP/ERR. No back-to-back overlap.
- Reset mid-operation: rst=0 at any edge forces IDLE and the reset values.
  - A write whose WR cycle ends at that edge still lands in memory, because mem_we was 1 when sampled.
  - No response is issued for the aborted request.
- ERR_ON_MISALIGN=0: misaligned halfword/word proceeds with addr[0] (halfword) or addr[1:0] (word) treated as 0, and resp_err=0. Reserved size still errors.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x10 → mem_we=1 one cycle, mem_addr=4, mem_wdata=0xDEADBEEF, resp_valid at T+2. Then lw @0x10 → resp_rdata=0xDEADBEEF at T+2.
- Byte load signed and unsigned: memory word 4 = 0x80FF7F01, loads @0x11 and @0x12:
  - lb @0x11 → 0x0000007F;
  - lb @0x12 → 0xFFFFFFFF;
  - lbu @0x12 → 0x000000FF.
- Sub-word read-modify-write: word 4 = 0x11223344.
  - sb 0xAA @0x13 → 0xAA223344 written at the T+2 edge, resp_valid at T+3.
  - sh 0xBEEF @0x10 → 0xAA22BEEF.
- Misaligned and reserved: lh @0x11, sw @0x12, size=11 → resp_valid and resp_err=1 at T+1, mem_we never asserted, memory unchanged.
- Handshake: req_valid held high for 3 back-to-back loads → req_ready=0 during RD/RESP, each accepted only in IDLE, exactly 3 resp_valid pulses, in order.
- Reset mid-op: assert rst=0 during the RD cycle of a sub-word store → no mem_we, no resp_valid, all outputs at reset values, req_ready=1 the next cycle.
